main_memory_port_ctrl: RTL
==========================

# main_memory_port_ctrl

Parametrised, handshaked successor to the single-cycle memory steering logic. It sits between the CPU stage sequencer and a variable-latency main memory. It issues at most one memory transaction per fetch or memory stage: instruction fetch from the PC, or data load/store. It holds the pipeline with `stall` until the memory acknowledges. Fetched instructions and load data are captured into registers that stay stable after completion.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: memory word width; must be a multiple of 8.
- `BE_WIDTH`, default `DATA_WIDTH/8`: byte-enable width.
- `TIMEOUT_CYCLES`, default 255: watchdog limit; only used with `MAIN_MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `stage` in `STAGE_WIDTH`: current CPU stage.
- `current_instr_type` in 5: instruction class (`INSTR_LOAD`, `INSTR_STORE`, ...).
- `PC_value` in ADDR_WIDTH: fetch address.
- `memory_read_address` in ADDR_WIDTH: load address.
- `memory_write_address` in ADDR_WIDTH: store address.
- `memory_write_data` in DATA_WIDTH: store data.
- `memory_byte_en` in BE_WIDTH: store byte enables.
- `stall` out 1: stage must not advance.
- `instr_data` out DATA_WIDTH: last fetched word.
- `load_data` out DATA_WIDTH: last loaded word.
- `access_done` out 1: one-cycle pulse when a transaction completes.
- `misaligned` out 1: one-cycle pulse when an access is rejected for alignment.
- `mem_req` out 1: memory request; held until acknowledged.
- `mem_we` out 1: request is a write.
- `mem_addr` out ADDR_WIDTH: request address.
- `mem_wdata` out DATA_WIDTH: write data.
- `mem_be` out BE_WIDTH: byte enables; all ones for reads.
- `mem_ack` in 1: transaction complete.
- `mem_rdata` in DATA_WIDTH: read data, valid when `mem_ack` is high.
- `timeout_err` out 1: sticky watchdog error; only present with the macro.

## Operation
- Access is needed when the stage is `STAGE_FETCH`, or when the stage is `STAGE_MEMORY` and the instruction type is `INSTR_LOAD` or `INSTR_STORE`.
- FSM states:
  - IDLE: no access in progress.
  - REQ: `mem_req` is high, waiting for `mem_ack`.
  - DONE: access for the current stage is complete.
  - ERR: watchdog fired (macro only).
- IDLE -> REQ when an access is needed and the address is aligned. Address, write data, byte enables and `mem_we` are latched on this edge and held constant through REQ.
- Alignment rule: the low `log2(BE_WIDTH)` address bits must be zero. If not, go IDLE -> DONE, pulse `misaligned`, and issue no request.
- REQ -> DONE on `mem_ack`:
  - Fetch: capture `mem_rdata` into `instr_data`.
  - Load: capture `mem_rdata` into `load_data`.
  - Store: capture nothing.
  - Pulse `access_done`.
- DONE -> IDLE when `stage` differs from its registered value at the last edge. A stage change clears the completion.
- `stall` = access needed AND state is not DONE. It is combinational from `stage`/`current_instr_type` and the state.
- `mem_ack` is ignored outside REQ.
- Reset values: state IDLE; `mem_req`, `mem_we`, `access_done`, `misaligned` and `timeout_err` are 0; `mem_addr`, `mem_wdata`, `instr_data` and `load_data` are 0; `mem_be` is 0.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous). A late `mem_ack` after reset is ignored.

## Timing
- Stage enters FETCH at edge N. `stall` goes high in the cycle after N. `mem_req` is registered and goes high after edge N+1.
- `mem_ack` in the first REQ cycle: DONE after the following edge. `stall` drops and `instr_data` is valid from cycle N+2. Minimum latency is 2 cycles; add 1 cycle per wait cycle of `mem_ack`.
- `access_done` and `misaligned` are high for exactly one cycle, aligned with entry to DONE.
- A misaligned access: `stall` is high for 1 cycle only.
- `instr_data` and `load_data` hold their value until the next capture of the same kind.

## Configuration
- `MAIN_MEM_TIMEOUT_EN` defined:
  - A counter runs in REQ, cleared on entry.
  - When the count reaches `TIMEOUT_CYCLES` without `mem_ack`: drop `mem_req`, set sticky `timeout_err`, enter ERR.
  - ERR keeps `stall` high and leaves only on reset.
- Macro not defined: no counter, no ERR state, no `timeout_err` port; REQ waits indefinitely.

## Structure
- The shared arch defines header owns `STAGE_WIDTH`, `STAGE_FETCH`, `STAGE_MEMORY`, `INSTR_LOAD`, `INSTR_STORE`, and the FSM state encodings (`MMPC_IDLE`, `MMPC_REQ`, `MMPC_DONE`, `MMPC_ERR`).
- One sub-module: `mem_timeout_counter`. It is instantiated only under the macro, with inputs `clk`, `rst`, `clear`, `enable` and output `expired`.

## Test plan
- Fetch with PC=0x100, memory acks 3 cycles after req: `mem_addr`=0x100, `mem_we`=0, `stall` high for 4 cycles, `instr_data` = returned 0xDEADBEEF, one `access_done` pulse.
- Store to 0x20 with data 0x12345678, BE=4'b0011, immediate ack: `mem_we`=1, `mem_be`=0011, exactly one req cycle, `load_data` unchanged.
- MEMORY stage with a non-memory instruction type: no `mem_req`, `stall` stays 0.
- Load at 0x22: no `mem_req`, `misaligned` pulses once, `stall` high for 1 cycle.
- `rst` asserted while in REQ, then `mem_ack` arrives 2 cycles later: `mem_req` is 0 immediately, the ack is ignored, `instr_data`=0.
- With the macro and `TIMEOUT_CYCLES`=8, no ack: `mem_req` drops after 8 REQ cycles, `timeout_err`=1, `stall` stays high until reset.

Source files
------------

// File: rtl/main_memory_port_ctrl_pkg.sv
// Shared definitions for the main memory port controller: CPU stage and
// instruction-class encodings, controller FSM states and the access decode
// helper used to decide whether the current stage needs a memory transaction.
package main_memory_port_ctrl_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE      = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_FETCH     = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_DECODE    = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_EXECUTE   = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEMORY    = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITEBACK = 3'd5;

    localparam logic [4:0] INSTR_NOP    = 5'd0;
    localparam logic [4:0] INSTR_ALU    = 5'd1;
    localparam logic [4:0] INSTR_BRANCH = 5'd2;
    localparam logic [4:0] INSTR_LOAD   = 5'd3;
    localparam logic [4:0] INSTR_STORE  = 5'd4;

    typedef enum logic [1:0] {
        MMPC_IDLE = 2'd0,
        MMPC_REQ  = 2'd1,
        MMPC_DONE = 2'd2,
        MMPC_ERR  = 2'd3
    } mmpc_state_e;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_FETCH = 2'd1,
        ACC_LOAD  = 2'd2,
        ACC_STORE = 2'd3
    } acc_kind_e;

    // Which transaction (if any) the given stage / instruction class needs.
    function automatic acc_kind_e decode_access(
        input logic [STAGE_WIDTH-1:0] stage,
        input logic [4:0]             instr_type
    );
        acc_kind_e kind;
        kind = ACC_NONE;
        if (stage == STAGE_FETCH) begin
            kind = ACC_FETCH;
        end else if (stage == STAGE_MEMORY && instr_type == INSTR_LOAD) begin
            kind = ACC_LOAD;
        end else if (stage == STAGE_MEMORY && instr_type == INSTR_STORE) begin
            kind = ACC_STORE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/main_memory_port_ctrl_mem_timeout_counter.sv
// Request watchdog for the main memory port controller. Down-counter loaded
// on clear; 'expired' is raised in the TIMEOUT_CYCLES-th enabled cycle after
// the clear, i.e. when the count has run down to zero while still enabled.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Reload on clear, otherwise count down while enabled and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= LOAD_VAL;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/main_memory_port_ctrl.sv
// Main memory port controller: issues one fetch / load / store transaction per
// CPU stage to a variable-latency memory, stalls the pipeline until the memory
// acknowledges, and keeps the fetched instruction and loaded data in registers.
// Optional request watchdog: define MAIN_MEM_TIMEOUT_EN to add the timeout
// counter, the ERR state and the sticky timeout_err output.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   MMPC_IDLE | no access in progress
//   MMPC_REQ  | mem_req high, waiting for mem_ack
//   MMPC_DONE | access for the current stage complete (or rejected)
//   MMPC_ERR  | watchdog fired; stall held until reset (watchdog only)
module main_memory_port_ctrl
    import main_memory_port_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic [4:0]             current_instr_type,
    input  logic [ADDR_WIDTH-1:0]  PC_value,
    input  logic [ADDR_WIDTH-1:0]  memory_read_address,
    input  logic [ADDR_WIDTH-1:0]  memory_write_address,
    input  logic [DATA_WIDTH-1:0]  memory_write_data,
    input  logic [BE_WIDTH-1:0]    memory_byte_en,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  instr_data,
    output logic [DATA_WIDTH-1:0]  load_data,
    output logic                   access_done,
    output logic                   misaligned,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [BE_WIDTH-1:0]    mem_be,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
`ifdef MAIN_MEM_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_WIDTH - 1);

    mmpc_state_e            state;
    mmpc_state_e            state_nxt;
    acc_kind_e              kind;
    logic                   access_needed;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   aligned;
    logic [STAGE_WIDTH-1:0] stage_q;
    logic                   stage_changed;
    logic                   done_valid;
    logic                   can_start;
    logic                   start_req;
    logic                   start_mis;
    logic                   req_is_fetch;
    logic                   expired;

    assign kind          = decode_access(stage, current_instr_type);
    assign access_needed = (kind != ACC_NONE);

    // Address source for the access the current stage needs.
    always_comb begin
        sel_addr = PC_value;
        case (kind)
            ACC_LOAD:  sel_addr = memory_read_address;
            ACC_STORE: sel_addr = memory_write_address;
            default:   sel_addr = PC_value;
        endcase
    end

    assign aligned = ((sel_addr & ALIGN_MASK) == '0);

    // A stage change clears the completion combinationally, so the new stage
    // stalls in its first cycle even while the state register still says DONE,
    // and DONE can launch the next access directly with the same 2-cycle
    // latency as IDLE.
    assign stage_changed = (stage != stage_q);
    assign done_valid    = (state == MMPC_DONE) && !stage_changed;
    assign can_start     = (state == MMPC_IDLE) || ((state == MMPC_DONE) && stage_changed);
    assign start_req     = can_start && access_needed && aligned;
    assign start_mis     = can_start && access_needed && !aligned;

    assign stall = (state == MMPC_ERR) || (access_needed && !done_valid);

`ifdef MAIN_MEM_TIMEOUT_EN
    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_req),
        .enable  (state == MMPC_REQ),
        .expired (expired)
    );

    // Sticky watchdog flag; only a reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (state == MMPC_REQ && !mem_ack && expired) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MMPC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the same cycle as expiry still completes.
    always_comb begin
        state_nxt = state;
        case (state)
            MMPC_IDLE, MMPC_DONE: begin
                if (start_req) begin
                    state_nxt = MMPC_REQ;
                end else if (start_mis) begin
                    state_nxt = MMPC_DONE;
                end else if (state == MMPC_DONE && stage_changed) begin
                    state_nxt = MMPC_IDLE;
                end
            end
            MMPC_REQ: begin
                if (mem_ack) begin
                    state_nxt = MMPC_DONE;
                end else if (expired) begin
                    state_nxt = MMPC_ERR;
                end
            end
            MMPC_ERR: begin
                state_nxt = MMPC_ERR;
            end
            default: begin
                state_nxt = MMPC_IDLE;
            end
        endcase
    end

    // Request latching, response capture and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            req_is_fetch <= 1'b0;
            instr_data   <= '0;
            load_data    <= '0;
            access_done  <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            stage_q     <= stage;
            access_done <= 1'b0;
            misaligned  <= start_mis;
            if (start_req) begin
                mem_req      <= 1'b1;
                mem_we       <= (kind == ACC_STORE);
                mem_addr     <= sel_addr;
                mem_wdata    <= (kind == ACC_STORE) ? memory_write_data : '0;
                mem_be       <= (kind == ACC_STORE) ? memory_byte_en : '1;
                req_is_fetch <= (kind == ACC_FETCH);
            end else if (state == MMPC_REQ && mem_ack) begin
                mem_req     <= 1'b0;
                access_done <= 1'b1;
                if (req_is_fetch) begin
                    instr_data <= mem_rdata;
                end else if (!mem_we) begin
                    load_data <= mem_rdata;
                end
            end else if (state == MMPC_REQ && expired) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule
